// File: rtl/branch_history_unit.sv
// -----------------------------------------------------------------------------
// branch_history_unit
//
// Front end of a gshare predictor. Builds PHT lookup indices from the fetch PC
// XORed with a speculative global history (sghr), and remembers every accepted
// prediction in an in-order queue. When the oldest branch resolves, its stored
// index is replayed to the PHT for training. The committed history (cghr) is
// used to repair sghr after a mispredict or a flush.
//
// Ports
//   clk               clock, all state on posedge
//   rst               asynchronous active-low reset
//   fetch_pc          PC of the fetch-stage branch
//   fetch_is_br       fetch-stage conditional branch, requests a lookup
//   predicted_branch  PHT prediction for pht_index (combinational from PHT)
//   pred_accept       lookup accepted this cycle, queue entry allocated
//   pred_taken        prediction returned to fetch (0 when not accepted)
//   resolve_valid     oldest in-flight branch resolved this cycle
//   resolve_taken     actual direction of the resolved branch
//   flush             discard all in-flight entries
//   mispredict        resolved direction differs from the stored prediction
//   pht_index         PHT index (update index or lookup index)
//   pht_ld            PHT counter update strobe
//   cpu_br_en         actual direction for the PHT update
//   ghr               speculative global history
//   inflight_count    occupied queue entries
//   full              queue is full
// -----------------------------------------------------------------------------
module branch_history_unit #(
  parameter int INDEX  = 4,
  parameter int DEPTH  = 4,
  parameter int PC_LSB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              fetch_pc,
  input  logic                     fetch_is_br,
  input  logic                     predicted_branch,
  output logic                     pred_accept,
  output logic                     pred_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     mispredict,
  output logic [INDEX-1:0]         pht_index,
  output logic                     pht_ld,
  output logic                     cpu_br_en,
  output logic [INDEX-1:0]         ghr,
  output logic [$clog2(DEPTH):0]   inflight_count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [INDEX-1:0] r_sghr;
  logic [INDEX-1:0] r_cghr;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [INDEX-1:0] r_q_idx  [DEPTH];
  logic             r_q_pred [DEPTH];

  logic [INDEX-1:0] w_lookup_idx;
  logic [INDEX-1:0] w_head_idx;
  logic             w_head_pred;
  logic             w_full;
  logic             w_upd;
  logic             w_lookup;
  logic             w_mispredict;
  logic [INDEX-1:0] w_cghr_next;
  logic [INDEX-1:0] w_sghr_push;

  assign w_lookup_idx = fetch_pc[PC_LSB +: INDEX] ^ r_sghr;
  assign w_head_idx   = r_q_idx[r_head];
  assign w_head_pred  = r_q_pred[r_head];
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_cghr_next  = {r_cghr[INDEX-2:0], resolve_taken};
  assign w_sghr_push  = {r_sghr[INDEX-2:0], predicted_branch};

  // rst is folded into the strobes so they drop the moment reset asserts,
  // not at the next clock edge.
  assign w_upd        = rst & resolve_valid & (r_count != '0);
  assign w_lookup     = rst & ~w_upd & fetch_is_br & ~w_full & ~flush;
  assign w_mispredict = w_upd & (resolve_taken != w_head_pred);

  always_comb begin
    pht_index   = w_lookup_idx;
    pht_ld      = 1'b0;
    cpu_br_en   = 1'b0;
    pred_accept = 1'b0;
    pred_taken  = 1'b0;
    mispredict  = 1'b0;
    if (w_upd) begin
      // The update owns the PHT port; fetch stalls this cycle.
      pht_index  = w_head_idx;
      pht_ld     = 1'b1;
      cpu_br_en  = resolve_taken;
      mispredict = w_mispredict;
    end else if (w_lookup) begin
      pred_accept = 1'b1;
      pred_taken  = predicted_branch;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sghr  <= '0;
      r_cghr  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_upd) begin
      r_cghr <= w_cghr_next;
      if (w_mispredict || flush) begin
        // Everything younger than the resolved branch is wrong-path; restart
        // speculation from the freshly committed history.
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_sghr  <= w_cghr_next;
      end else begin
        r_head  <= r_head + 1'b1;
        r_count <= r_count - 1'b1;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_sghr  <= r_cghr;
    end else if (w_lookup) begin
      r_tail  <= r_tail + 1'b1;
      r_count <= r_count + 1'b1;
      r_sghr  <= w_sghr_push;
    end
  end

  // Entry payload needs no reset: an entry is only read while count > 0,
  // and it is always written before it is counted.
  always_ff @(posedge clk) begin
    if (w_lookup) begin
      r_q_idx[r_tail]  <= w_lookup_idx;
      r_q_pred[r_tail] <= predicted_branch;
    end
  end

  assign ghr            = r_sghr;
  assign inflight_count = r_count;
  assign full           = w_full;

endmodule

// File: tb/tb_branch_history_unit.sv
module tb_branch_history_unit;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_is_br;
  logic        predicted_branch;
  logic        pred_accept;
  logic        pred_taken;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        flush;
  logic        mispredict;
  logic [3:0]  pht_index;
  logic        pht_ld;
  logic        cpu_br_en;
  logic [3:0]  ghr;
  logic [2:0]  inflight_count;
  logic        full;

  branch_history_unit #(.INDEX(4), .DEPTH(4), .PC_LSB(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .fetch_is_br      (fetch_is_br),
    .predicted_branch (predicted_branch),
    .pred_accept      (pred_accept),
    .pred_taken       (pred_taken),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .mispredict       (mispredict),
    .pht_index        (pht_index),
    .pht_ld           (pht_ld),
    .cpu_br_en        (cpu_br_en),
    .ghr              (ghr),
    .inflight_count   (inflight_count),
    .full             (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected in that cycle. ghr/cnt/full
  // are the state before the cycle's clock edge, so each row also checks the
  // effect of the previous row.
  typedef struct {
    logic        br;
    logic [31:0] pc;
    logic        pb;
    logic        rv;
    logic        rt;
    logic        fl;
    logic        acc;
    logic        pt;
    logic [3:0]  idx;
    logic        ld;
    logic        ben;
    logic        mis;
    logic [3:0]  ghr;
    logic [2:0]  cnt;
    logic        full;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(input logic br, input logic [31:0] pc, input logic pb,
                              input logic rv, input logic rt, input logic fl,
                              input logic acc, input logic pt, input logic [3:0] idx,
                              input logic ld, input logic ben, input logic mis,
                              input logic [3:0] g, input logic [2:0] cnt, input logic fu);
    vec_t v;
    v.br = br; v.pc = pc; v.pb = pb; v.rv = rv; v.rt = rt; v.fl = fl;
    v.acc = acc; v.pt = pt; v.idx = idx; v.ld = ld; v.ben = ben; v.mis = mis;
    v.ghr = g; v.cnt = cnt; v.full = fu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    fetch_is_br      = v.br;
    fetch_pc         = v.pc;
    predicted_branch = v.pb;
    resolve_valid    = v.rv;
    resolve_taken    = v.rt;
    flush            = v.fl;
  endtask

  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    chk({tag, " pred_accept"},    pred_accept,    e.acc);
    chk({tag, " pred_taken"},     pred_taken,     e.pt);
    chk({tag, " pht_index"},      pht_index,      e.idx);
    chk({tag, " pht_ld"},         pht_ld,         e.ld);
    if (e.ld) chk({tag, " cpu_br_en"}, cpu_br_en, e.ben);
    chk({tag, " mispredict"},     mispredict,     e.mis);
    chk({tag, " ghr"},            ghr,            e.ghr);
    chk({tag, " inflight_count"}, inflight_count, e.cnt);
    chk({tag, " full"},           full,           e.full);
  endtask

  vec_t main_tbl [17];
  vec_t flush_tbl[12];

  initial begin
    //                 br  pc     pb rv rt fl  acc pt idx  ld ben mis  ghr cnt full
    main_tbl[0]  = mk(1, 'h10, 1, 0, 0, 0,  1, 1, 4'h4, 0, 0, 0, 4'h0, 0, 0);
    main_tbl[1]  = mk(1, 'h00, 0, 0, 0, 0,  1, 0, 4'h1, 0, 0, 0, 4'h1, 1, 0);
    main_tbl[2]  = mk(1, 'h04, 1, 0, 0, 0,  1, 1, 4'h3, 0, 0, 0, 4'h2, 2, 0);
    main_tbl[3]  = mk(1, 'h3C, 1, 0, 0, 0,  1, 1, 4'hA, 0, 0, 0, 4'h5, 3, 0);
    main_tbl[4]  = mk(1, 'h08, 1, 0, 0, 0,  0, 0, 4'h9, 0, 0, 0, 4'hB, 4, 1);
    main_tbl[5]  = mk(1, 'h08, 1, 1, 1, 0,  0, 0, 4'h4, 1, 1, 0, 4'hB, 4, 1);
    main_tbl[6]  = mk(1, 'h08, 0, 0, 0, 0,  1, 0, 4'h9, 0, 0, 0, 4'hB, 3, 0);
    main_tbl[7]  = mk(0, 'h00, 0, 1, 0, 0,  0, 0, 4'h1, 1, 0, 0, 4'h6, 4, 1);
    main_tbl[8]  = mk(0, 'h00, 0, 1, 0, 0,  0, 0, 4'h3, 1, 0, 1, 4'h6, 3, 0);
    main_tbl[9]  = mk(0, 'h00, 0, 0, 0, 0,  0, 0, 4'h4, 0, 0, 0, 4'h4, 0, 0);
    main_tbl[10] = mk(1, 'h00, 0, 1, 1, 0,  1, 0, 4'h4, 0, 0, 0, 4'h4, 0, 0);
    main_tbl[11] = mk(1, 'h14, 1, 0, 0, 0,  1, 1, 4'hD, 0, 0, 0, 4'h8, 1, 0);
    main_tbl[12] = mk(1, 'h00, 1, 0, 0, 1,  0, 0, 4'h1, 0, 0, 0, 4'h1, 2, 0);
    main_tbl[13] = mk(1, 'h00, 1, 0, 0, 0,  1, 1, 4'h4, 0, 0, 0, 4'h4, 0, 0);
    main_tbl[14] = mk(1, 'h04, 0, 0, 0, 0,  1, 0, 4'h8, 0, 0, 0, 4'h9, 1, 0);
    main_tbl[15] = mk(1, 'h00, 0, 1, 1, 1,  0, 0, 4'h4, 1, 1, 0, 4'h2, 2, 0);
    main_tbl[16] = mk(0, 'h00, 0, 0, 0, 0,  0, 0, 4'h9, 0, 0, 0, 4'h9, 0, 0);

    // After a reset: commit history 1,0 (cghr=0010), three lookups, flush,
    // then flush coinciding with a mispredicting update.
    flush_tbl[0]  = mk(1, 'h00, 1, 0, 0, 0,  1, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0);
    flush_tbl[1]  = mk(1, 'h00, 0, 0, 0, 0,  1, 0, 4'h1, 0, 0, 0, 4'h1, 1, 0);
    flush_tbl[2]  = mk(0, 'h00, 0, 1, 1, 0,  0, 0, 4'h0, 1, 1, 0, 4'h2, 2, 0);
    flush_tbl[3]  = mk(0, 'h00, 0, 1, 0, 0,  0, 0, 4'h1, 1, 0, 0, 4'h2, 1, 0);
    flush_tbl[4]  = mk(1, 'h00, 1, 0, 0, 0,  1, 1, 4'h2, 0, 0, 0, 4'h2, 0, 0);
    flush_tbl[5]  = mk(1, 'h00, 1, 0, 0, 0,  1, 1, 4'h5, 0, 0, 0, 4'h5, 1, 0);
    flush_tbl[6]  = mk(1, 'h00, 1, 0, 0, 0,  1, 1, 4'hB, 0, 0, 0, 4'hB, 2, 0);
    flush_tbl[7]  = mk(0, 'h00, 0, 0, 0, 1,  0, 0, 4'h7, 0, 0, 0, 4'h7, 3, 0);
    flush_tbl[8]  = mk(0, 'h00, 0, 0, 0, 0,  0, 0, 4'h2, 0, 0, 0, 4'h2, 0, 0);
    flush_tbl[9]  = mk(1, 'h00, 1, 0, 0, 0,  1, 1, 4'h2, 0, 0, 0, 4'h2, 0, 0);
    flush_tbl[10] = mk(0, 'h00, 0, 1, 0, 1,  0, 0, 4'h2, 1, 0, 1, 4'h5, 1, 0);
    flush_tbl[11] = mk(0, 'h00, 0, 0, 0, 0,  0, 0, 4'h4, 0, 0, 0, 4'h4, 0, 0);

    // Reset held with requests present: strobes must stay low.
    rst = 1'b0;
    drive(mk(1, 'h10, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #2;
    chk("rst pred_accept",    pred_accept,    0);
    chk("rst pht_ld",         pht_ld,         0);
    chk("rst mispredict",     mispredict,     0);
    chk("rst ghr",            ghr,            0);
    chk("rst inflight_count", inflight_count, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 17; i++) apply($sformatf("main%0d", i), main_tbl[i]);

    // Async reset between clock edges while an update is being presented.
    apply("async_pre", mk(1, 'h00, 1, 0, 0, 0, 1, 1, 4'h9, 0, 0, 0, 4'h9, 0, 0));
    @(negedge clk);
    drive(mk(1, 'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("async before pht_ld",     pht_ld,         1);
    chk("async before mispredict", mispredict,     1);
    chk("async before count",      inflight_count, 1);
    #1 rst = 1'b0;
    #1;
    chk("async inflight_count", inflight_count, 0);
    chk("async ghr",            ghr,            0);
    chk("async pht_ld",         pht_ld,         0);
    chk("async mispredict",     mispredict,     0);
    chk("async pred_accept",    pred_accept,    0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) apply($sformatf("flush%0d", i), flush_tbl[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_history_unit.md
Name: branch_history_unit

Overview:
- Sits directly upstream of the pattern history table (PHT). Drives its index, load enable and branch-taken inputs, and consumes its prediction bit.
- Forms gshare lookup indices from the fetch PC XORed with a speculative global history register (GHR).
- Keeps an in-order queue of in-flight predictions. At branch resolution it replays the stored index to train the PHT and repairs the GHR on mispredict or flush.

Parameters:
- INDEX, 4, PHT index width; also the GHR width. Must be >= 2.
- DEPTH, 4, in-flight prediction queue entries. Power of 2, >= 2.
- PC_LSB, 2, lowest fetch_pc bit used for indexing.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- fetch_pc  in  32  PC of the fetch-stage branch.
- fetch_is_br  in  1  fetch-stage instruction is a conditional branch; requests a lookup.
- predicted_branch  in  1  PHT prediction for the current pht_index (combinational).
- pred_accept  out  1  lookup accepted this cycle; entry allocated.
- pred_taken  out  1  prediction returned to fetch; valid only when pred_accept=1.
- resolve_valid  in  1  oldest in-flight branch resolved this cycle.
- resolve_taken  in  1  actual direction of the resolved branch.
- flush  in  1  pipeline flush; discard all in-flight entries.
- mispredict  out  1  resolved direction differed from the stored prediction.
- pht_index  out  INDEX  index to the PHT.
- pht_ld  out  1  PHT counter update strobe.
- cpu_br_en  out  1  actual direction for the PHT update.
- ghr  out  INDEX  speculative GHR (debug and perf).
- inflight_count  out  $clog2(DEPTH)+1  occupied queue entries.
- full  out  1  inflight_count == DEPTH.

Behaviour:
- State:
  - sghr (speculative GHR) and cghr (committed GHR), both INDEX bits.
  - Circular queue of DEPTH entries, each {index[INDEX-1:0], pred}, with head/tail pointers and a count.
  - Reset values: sghr=0, cghr=0, count=0, pointers=0. Assertion is asynchronous: state clears immediately, even mid-operation.
- Combinational outputs:
  - During reset: pht_ld=0, pred_accept=0, mispredict=0.
  - All other cycles follow the rules below.
- lookup_idx = fetch_pc[PC_LSB+INDEX-1:PC_LSB] XOR sghr.
- Update cycle (upd): resolve_valid=1 and count>0.
  - pht_index = head.index, pht_ld=1, cpu_br_en=resolve_taken.
  - mispredict = (resolve_taken != head.pred).
  - pred_accept=0: the update has the PHT port, so fetch stalls this cycle.
  - On the clock edge: pop head; cghr <= {cghr[INDEX-2:0], resolve_taken}.
- resolve_valid with count==0: ignored. No PHT update, mispredict=0, no state change.
- Lookup cycle: no upd, fetch_is_br=1, full=0, flush=0.
  - pht_index = lookup_idx, pred_accept=1, pred_taken=predicted_branch.
  - On the clock edge: push {lookup_idx, predicted_branch}; sghr <= {sghr[INDEX-2:0], predicted_branch}.
- Otherwise: pht_index = lookup_idx, pht_ld=0, pred_accept=0, and pred_taken is don't-care (drive 0).
- Mispredict on upd:
  - Clear the whole queue (count=0, head=tail).
  - sghr <= {cghr[INDEX-2:0], resolve_taken}, so sghr matches the new cghr.
- flush without upd: clear the queue and set sghr <= cghr.
- flush with upd:
  - The update is performed first: PHT write, cghr shift, mispredict evaluated.
  - Then the queue clears and sghr <= the new cghr.
- full=1 blocks lookups (pred_accept=0). Pop and push never coincide, because upd blocks lookup.
- Latency:
  - Prediction is same-cycle; the new sghr is visible the next cycle.
  - The PHT update strobe is same-cycle as resolve_valid.
- Pointer wrap-around is modulo DEPTH.

Test Plan (INDEX=4, DEPTH=4, PC_LSB=2):
- Reset release, fetch_is_br=1, fetch_pc=0x00000010, predicted_branch=1 -> pht_index=4'h4, pred_accept=1, pred_taken=1. Next cycle ghr=4'b0001, inflight_count=1.
- Four accepted lookups with predictions 1,0,1,1 -> ghr=4'b1011, full=1. Fifth request -> pred_accept=0, no state change.
- Resolve head with resolve_taken=1 (pred 1) -> pht_ld=1, cpu_br_en=1, pht_index=head index, mispredict=0. Count 4->3, cghr=4'b0001, and the stall frees a slot.
- Two entries with preds 1,1; resolve_taken=0 -> mispredict=1, pht_ld=1, cpu_br_en=0. Next cycle count=0, ghr=cghr=4'b0000.
- resolve_valid=1 with fetch_is_br=1 in the same cycle -> pred_accept=0, pht_index=head index. Also: resolve_valid with count=0 -> pht_ld=0, mispredict=0.
- Mid-stream checks:
  - flush with 3 entries and cghr=4'b0010 -> count=0, ghr=4'b0010.
  - Async rst=0 mid-cycle -> inflight_count=0, ghr=0 and pht_ld=0 immediately, without waiting for a clock edge.
